// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1:2 packet router.
package demux_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNTW_DEF  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ROUTE = 1'b1
  } state_e;

endpackage

// File: rtl/out_slot.sv
// One-entry valid/ready register slice feeding one router output.
module out_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             q_last,
  output logic             free
);

  // Load wins over drain so a simultaneous load+drain keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      q      <= '0;
      q_last <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q      <= d;
      q_last <= last;
    end else if (ready) begin
      valid  <= 1'b0;
    end
  end

  assign free = !valid || ready;

endmodule

// File: rtl/demux_1x2_packet_router.sv
// Steers one packet stream to y0 or y1; the select is locked for a whole packet.
module demux_1x2_packet_router
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             s,
  output logic [WIDTH-1:0] y0_data,
  output logic             y0_valid,
  output logic             y0_last,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic             y1_valid,
  output logic             y1_last,
  input  logic             y1_ready,
  output logic             busy,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic [CNTW-1:0] cnt0_q, cnt1_q;
  logic            inc0, inc1;
  logic            tgt, accept;
  logic            free0, free1;
  logic            load0, load1;

  // Destination is the live select only between packets.
  assign tgt      = (state_q == ST_IDLE) ? s : sel_q;
  assign in_ready = tgt ? free1 : free0;
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !tgt;
  assign load1    = accept && tgt;

  out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk    (clk),
    .rst    (rst),
    .load   (load0),
    .d      (in_data),
    .last   (in_last),
    .ready  (y0_ready),
    .valid  (y0_valid),
    .q      (y0_data),
    .q_last (y0_last),
    .free   (free0)
  );

  out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk    (clk),
    .rst    (rst),
    .load   (load1),
    .d      (in_data),
    .last   (in_last),
    .ready  (y1_ready),
    .valid  (y1_valid),
    .q      (y1_data),
    .q_last (y1_last),
    .free   (free1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (inc0) cnt0_q <= cnt0_q + CNTW'(1);
      if (inc1) cnt1_q <= cnt1_q + CNTW'(1);
    end
  end

  // Next state; counters bump when a packet's last beat is accepted.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    inc0    = 1'b0;
    inc1    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_last) begin
            inc0 = !s;
            inc1 = s;
          end else begin
            sel_d   = s;
            state_d = ST_ROUTE;
          end
        end
      end
      ST_ROUTE: begin
        if (accept && in_last) begin
          inc0    = !sel_q;
          inc1    = sel_q;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign busy = (state_q == ST_ROUTE);
  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux_1x2_packet_router.sv
// Directed and randomized checks of the 1:2 packet router against a queue model.
module tb_demux_1x2_packet_router;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       s;
  logic [7:0] y0_data, y1_data;
  logic       y0_valid, y1_valid;
  logic       y0_last, y1_last;
  logic       y0_ready, y1_ready;
  logic       busy;
  logic [7:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  demux_1x2_packet_router dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .s        (s),
    .y0_data  (y0_data),
    .y0_valid (y0_valid),
    .y0_last  (y0_last),
    .y0_ready (y0_ready),
    .y1_data  (y1_data),
    .y1_valid (y1_valid),
    .y1_last  (y1_last),
    .y1_ready (y1_ready),
    .busy     (busy),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic [7:0] d, input logic l);
    in_valid = v;
    s        = sel;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_y0_valid"}, y0_valid, 0);
    chk({tag, "_y1_valid"}, y1_valid, 0);
    chk({tag, "_y0_data"},  y0_data,  0);
    chk({tag, "_y1_data"},  y1_data,  0);
    chk({tag, "_y0_last"},  y0_last,  0);
    chk({tag, "_y1_last"},  y1_last,  0);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_cnt0"},     cnt0,     0);
    chk({tag, "_cnt1"},     cnt1,     0);
  endtask

  // Reference model state for the randomized phase
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         in_pkt;
  bit         pkt_dst;
  int         m_cnt0, m_cnt1;

  initial begin
    logic [7:0] d;
    logic       v, sel, l, dst, exp_rdy;

    rst = 1'b1;
    drive(0, 0, 8'h00, 0);
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single-beat packet to y0
    drive(1, 0, 8'hA5, 1);
    #1 chk("single_in_ready", in_ready, 1);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("single_y0_valid", y0_valid, 1);
    chk("single_y0_data",  y0_data,  8'hA5);
    chk("single_y0_last",  y0_last,  1);
    chk("single_y1_valid", y1_valid, 0);
    chk("single_cnt0",     cnt0,     1);
    chk("single_busy",     busy,     0);
    tick();
    chk("single_drained",  y0_valid, 0);

    // Three-beat packet to y1; select toggles mid-packet
    drive(1, 1, 8'h11, 0);
    tick();
    chk("pkt3_b1_data", y1_data, 8'h11);
    chk("pkt3_b1_busy", busy, 1);
    drive(1, 0, 8'h22, 0);
    tick();
    chk("pkt3_b2_data",   y1_data,  8'h22);
    chk("pkt3_b2_y0",     y0_valid, 0);
    chk("pkt3_b2_busy",   busy,     1);
    drive(1, 0, 8'h33, 1);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("pkt3_b3_data",   y1_data,  8'h33);
    chk("pkt3_b3_last",   y1_last,  1);
    chk("pkt3_b3_y0",     y0_valid, 0);
    chk("pkt3_b3_busy",   busy,     0);
    chk("pkt3_cnt1",      cnt1,     1);
    tick();

    // Back-pressure on y1
    y1_ready = 1'b0;
    drive(1, 1, 8'h66, 1);
    tick();
    chk("bp_first_data", y1_data, 8'h66);
    drive(1, 1, 8'h77, 1);
    #1 chk("bp_in_ready_low", in_ready, 0);
    tick();
    chk("bp_hold_data",  y1_data,  8'h66);
    chk("bp_hold_valid", y1_valid, 1);
    chk("bp_hold_cnt1",  cnt1,     2);
    y1_ready = 1'b1;
    #1 chk("bp_in_ready_high", in_ready, 1);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("bp_resume_data", y1_data,  8'h77);
    chk("bp_resume_cnt1", cnt1,     3);
    tick();
    chk("bp_no_dup",      y1_valid, 0);

    // y0 packet proceeds while y1 is stalled
    y1_ready = 1'b0;
    drive(1, 1, 8'h44, 1);
    tick();
    drive(1, 0, 8'h55, 1);
    #1 chk("conc_in_ready", in_ready, 1);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("conc_y0_data",  y0_data,  8'h55);
    chk("conc_y0_valid", y0_valid, 1);
    chk("conc_y1_data",  y1_data,  8'h44);
    chk("conc_y1_valid", y1_valid, 1);
    y1_ready = 1'b1;
    tick();

    // Asynchronous reset in the middle of a packet to y1
    drive(1, 1, 8'h81, 0);
    tick();
    drive(1, 1, 8'h82, 0);
    tick();
    chk("mid_busy_before", busy, 1);
    drive(0, 0, 8'h00, 0);
    rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    #2 rst = 1'b0;
    tick();
    drive(1, 0, 8'h90, 1);
    tick();
    drive(0, 0, 8'h00, 0);
    chk("post_rst_y0_data",  y0_data,  8'h90);
    chk("post_rst_y0_valid", y0_valid, 1);
    chk("post_rst_y1_valid", y1_valid, 0);
    chk("post_rst_cnt0",     cnt0,     1);

    // 256 single-beat packets to y0 wrap the counter
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      drive(1, 0, d, 1);
      tick();
      chk("wrap_y0_data", y0_data, d);
      chk("wrap_cnt0",    cnt0,    32'((i + 1) % 256));
    end
    drive(0, 0, 8'h00, 0);
    chk("wrap_cnt0_final", cnt0, 0);
    chk("wrap_cnt1_final", cnt1, 0);
    tick();

    // Randomized traffic against a packet-level queue model
    rst = 1'b1;
    #1 rst = 1'b0;
    in_pkt = 0; pkt_dst = 0; m_cnt0 = 0; m_cnt1 = 0;
    q0.delete(); q1.delete();
    for (int n = 0; n < 2000; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      l   = ($urandom_range(0, 2) == 0);
      y0_ready = ($urandom_range(0, 3) != 0);
      y1_ready = ($urandom_range(0, 3) != 0);
      drive(v, sel, d, l);
      #1;
      dst = in_pkt ? pkt_dst : sel;
      exp_rdy = dst ? (q1.size() == 0 || y1_ready) : (q0.size() == 0 || y0_ready);
      chk("rnd_in_ready", in_ready, exp_rdy);
      @(posedge clk);
      if (q0.size() > 0 && y0_ready) void'(q0.pop_front());
      if (q1.size() > 0 && y1_ready) void'(q1.pop_front());
      if (v && exp_rdy) begin
        if (dst) q1.push_back({l, d});
        else     q0.push_back({l, d});
        if (l) begin
          if (dst) m_cnt1 = (m_cnt1 + 1) % 256;
          else     m_cnt0 = (m_cnt0 + 1) % 256;
          in_pkt = 0;
        end else begin
          in_pkt  = 1;
          pkt_dst = dst;
        end
      end
      #1;
      chk("rnd_y0_valid", y0_valid, q0.size() != 0);
      chk("rnd_y1_valid", y1_valid, q1.size() != 0);
      if (q0.size() != 0) begin
        chk("rnd_y0_data", y0_data, q0[0][7:0]);
        chk("rnd_y0_last", y0_last, q0[0][8]);
      end
      if (q1.size() != 0) begin
        chk("rnd_y1_data", y1_data, q1[0][7:0]);
        chk("rnd_y1_last", y1_last, q1[0][8]);
      end
      chk("rnd_busy", busy, in_pkt);
      chk("rnd_cnt0", cnt0, m_cnt0);
      chk("rnd_cnt1", cnt1, m_cnt1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
